// File: rtl/ip_tone_gen.sv
// I/O-mapped square-wave tone generator: programmable half-period, volume and
// optional millisecond duration, producing a gated level for the PWM stage.
module ip_tone_gen #(
  parameter logic [7:0]  io_address = 8'h10,
  parameter int unsigned ms_divider = 1000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        enable_1mhz,
  input  logic [15:0] bus_address,
  input  logic        bus_io,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [7:0]  bus_write_data,
  output logic        bus_io_cs,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  output logic [15:0] signal_level,
  output logic        tone_active
);

  localparam int MS_W = (ms_divider > 1) ? $clog2(ms_divider) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(ms_divider - 1);

  logic [15:0]     period;
  logic [15:0]     div_cnt;
  logic [7:0]      shadow_lo;
  logic [7:0]      volume;
  logic [7:0]      dur_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic            enable;
  logic            busy;
  logic            phase;

  logic [2:0] offset;
  logic       wr_any;
  logic       rd_any;
  logic       wr_lo, wr_hi, wr_vol, wr_ctrl, wr_dur;
  logic       ms_tick;
  logic       expire;
  logic [7:0] rd_mux;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^bus_address[15:8];

  // Base is 8-aligned, so the low three address bits are the register offset.
  assign offset    = bus_address[2:0];
  assign bus_io_cs = bus_io && (bus_address[7:3] == io_address[7:3]) && (offset <= 3'd4);

  assign wr_any  = bus_write && bus_io_cs;
  assign rd_any  = bus_read && bus_io_cs;
  assign wr_lo   = wr_any && (offset == 3'd0);
  assign wr_hi   = wr_any && (offset == 3'd1);
  assign wr_vol  = wr_any && (offset == 3'd2);
  assign wr_ctrl = wr_any && (offset == 3'd3);
  assign wr_dur  = wr_any && (offset == 3'd4);

  assign tone_active = enable && (period != 16'd0);

  // A CPU write to control or duration in the expiry clk cancels the auto-stop.
  assign ms_tick = enable_1mhz && busy && (ms_cnt == MS_LAST);
  assign expire  = ms_tick && (dur_cnt == 8'd1) && !wr_ctrl && !wr_dur;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      period    <= 16'd0;
      shadow_lo <= 8'd0;
      volume    <= 8'hFF;
      enable    <= 1'b0;
      busy      <= 1'b0;
      div_cnt   <= 16'd0;
      phase     <= 1'b0;
      ms_cnt    <= '0;
      dur_cnt   <= 8'd0;
    end else begin
      if (wr_lo)  shadow_lo <= bus_write_data;
      if (wr_hi)  period    <= {bus_write_data, shadow_lo};
      if (wr_vol) volume    <= bus_write_data;

      // Reload reads the pre-write period, so a new period starts on a clean edge.
      if (enable_1mhz) begin
        if (!enable || (period == 16'd0)) begin
          div_cnt <= 16'd0;
          phase   <= 1'b0;
        end else if (div_cnt == 16'd0) begin
          div_cnt <= period;
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt - 16'd1;
        end
      end

      if (enable_1mhz && busy) begin
        ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
        if (ms_tick) begin
          dur_cnt <= dur_cnt - 8'd1;
          if (dur_cnt == 8'd1) busy <= 1'b0;
        end
      end

      if (expire) begin
        enable <= 1'b0;
        phase  <= 1'b0;
      end

      if (wr_ctrl) begin
        enable <= bus_write_data[0];
        if (!bus_write_data[0]) busy <= 1'b0;
      end

      if (wr_dur) begin
        if (bus_write_data == 8'd0) begin
          busy <= 1'b0;
        end else begin
          dur_cnt <= bus_write_data;
          ms_cnt  <= '0;
          busy    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      3'd0:    rd_mux = period[7:0];
      3'd1:    rd_mux = period[15:8];
      3'd2:    rd_mux = volume;
      3'd3:    rd_mux = {phase, 5'b00000, busy, enable};
      3'd4:    rd_mux = dur_cnt;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus_read_ready <= 1'b0;
      bus_read_data  <= 8'h00;
    end else begin
      bus_read_ready <= rd_any;
      if (rd_any) bus_read_data <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) signal_level <= 16'h0000;
    else          signal_level <= (phase && enable) ? {volume, 8'h00} : 16'h0000;
  end

endmodule

// File: tb/tb_ip_tone_gen.sv
// Bench for ip_tone_gen: read scoreboard plus a level-edge scoreboard that
// checks the value and tick spacing of every signal_level change.
module tb_ip_tone_gen;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        enable_1mhz = 1'b0;
  logic [15:0] bus_address = 16'h0000;
  logic        bus_io = 1'b0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [7:0]  bus_write_data = 8'h00;
  logic        bus_io_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [15:0] signal_level;
  logic        tone_active;

  ip_tone_gen #(.io_address(8'h10), .ms_divider(1000)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .enable_1mhz    (enable_1mhz),
    .bus_address    (bus_address),
    .bus_io         (bus_io),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_write_data (bus_write_data),
    .bus_io_cs      (bus_io_cs),
    .bus_read_ready (bus_read_ready),
    .bus_read_data  (bus_read_data),
    .signal_level   (signal_level),
    .tone_active    (tone_active)
  );

  typedef struct { logic [7:0] data; int due; string name; } rd_exp_t;
  typedef struct { logic [15:0] val; int ivl; string name; } lvl_exp_t;

  rd_exp_t     rd_q[$];
  lvl_exp_t    lvl_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tick_cnt = 0;
  int          lvl_tick = 0;
  logic [15:0] lvl_last = 16'h0000;
  bit          lvl_mon = 1'b0;

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: one clk of latency for reads; level edges checked for value and spacing.
  always @(posedge clk) begin
    rd_exp_t  e;
    lvl_exp_t le;
    cyc++;
    if (enable_1mhz) tick_cnt++;
    #1;
    if (bus_read_ready) begin
      if (rd_q.size() == 0) begin
        chk("spurious_ready", bus_read_ready, 1'b0);
      end else begin
        e = rd_q.pop_front();
        chk({e.name, "_data"}, bus_read_data, e.data);
        chk({e.name, "_latency"}, cyc, e.due);
      end
    end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
      e = rd_q.pop_front();
      chk({e.name, "_timeout"}, bus_read_ready, 1'b1);
    end
    if (signal_level !== lvl_last) begin
      if (lvl_mon) begin
        if (lvl_q.size() == 0) begin
          chk("spurious_level", signal_level, lvl_last);
        end else begin
          le = lvl_q.pop_front();
          chk({le.name, "_val"}, signal_level, le.val);
          if (le.ivl >= 0) chk({le.name, "_ivl"}, tick_cnt - lvl_tick, le.ivl);
        end
      end
      lvl_last = signal_level;
      lvl_tick = tick_cnt;
    end
  end

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    bus_address = {8'hA5, 8'h10 | {5'b00000, off}};
    bus_io = 1'b1; bus_write = 1'b1; bus_write_data = d;
    @(negedge clk);
    bus_write = 1'b0; bus_io = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus_address = {8'hA5, 8'h10 | {5'b00000, off}};
    bus_io = 1'b1; bus_read = 1'b1;
    rd_q.push_back(rd_exp_t'{exp, cyc + 1, name});
    @(negedge clk);
    bus_read = 1'b0; bus_io = 1'b0;
  endtask

  task automatic rd_nodec(input logic [15:0] addr, input logic io, input string name);
    @(negedge clk);
    bus_address = addr; bus_io = io; bus_read = 1'b1;
    @(posedge clk);
    #2 chk(name, bus_read_ready, 1'b0);
    @(negedge clk);
    bus_read = 1'b0; bus_io = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      @(negedge clk) enable_1mhz = 1'b1;
      @(negedge clk) enable_1mhz = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic exp_lvl(input logic [15:0] v, input int ivl, input string name);
    lvl_q.push_back(lvl_exp_t'{v, ivl, name});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("rst_level", signal_level, 16'h0000);
    chk("rst_active", tone_active, 1'b0);
    chk("rst_ready", bus_read_ready, 1'b0);

    // Address decode
    bus_io = 1'b1; bus_address = 16'hA514; #1 chk("cs_top", bus_io_cs, 1'b1);
    bus_address = 16'h0015; #1 chk("cs_past_top", bus_io_cs, 1'b0);
    bus_address = 16'h000F; #1 chk("cs_below", bus_io_cs, 1'b0);
    bus_address = 16'hFF10; #1 chk("cs_base", bus_io_cs, 1'b1);
    bus_io = 1'b0; #1 chk("cs_mem", bus_io_cs, 1'b0);

    rd(3'd2, 8'hFF, "rst_vol");
    rd(3'd3, 8'h00, "rst_ctrl");
    rd(3'd0, 8'h00, "rst_plo");
    rd(3'd4, 8'h00, "rst_dur");
    rd_nodec(16'h0015, 1'b1, "nodec_15");
    rd_nodec(16'h0012, 1'b0, "nodec_mem");

    // Period 1234, volume 0x80
    wr(3'd0, 8'hD2); wr(3'd1, 8'h04); wr(3'd2, 8'h80); wr(3'd3, 8'h01);
    chk("t2_active", tone_active, 1'b1);
    rd(3'd0, 8'hD2, "t2_plo");
    rd(3'd1, 8'h04, "t2_phi");
    rd(3'd2, 8'h80, "t2_vol");
    lvl_mon = 1'b1;
    exp_lvl(16'h8000, -1, "t2_first");
    exp_lvl(16'h0000, 1235, "t2_fall");
    exp_lvl(16'h8000, 1235, "t2_rise");
    run_ticks(1 + 2 * 1235);

    // High byte only mid half-cycle: old length finishes, then 211-tick halves
    run_ticks(100);
    wr(3'd1, 8'h00);
    rd(3'd1, 8'h00, "t3_phi");
    rd(3'd0, 8'hD2, "t3_plo");
    exp_lvl(16'h0000, 1235, "t3_old");
    exp_lvl(16'h8000, 211, "t3_new1");
    exp_lvl(16'h0000, 211, "t3_new2");
    run_ticks(1135 + 211 + 211);
    lvl_mon = 1'b0;

    // 3 ms duration at period 4
    wr(3'd3, 8'h00);
    run_ticks(1);
    wr(3'd0, 8'h04); wr(3'd1, 8'h00); wr(3'd3, 8'h01); wr(3'd4, 8'd3);
    rd(3'd3, 8'h03, "t4_busy");
    rd(3'd4, 8'h03, "t4_dur");
    run_ticks(2999);
    rd(3'd3, 8'h03, "t4_pre_ctrl");
    rd(3'd4, 8'h01, "t4_pre_dur");
    chk("t4_pre_active", tone_active, 1'b1);
    run_ticks(1);
    rd(3'd3, 8'h00, "t4_post_ctrl");
    rd(3'd4, 8'h00, "t4_post_dur");
    chk("t4_post_level", signal_level, 16'h0000);
    chk("t4_post_active", tone_active, 1'b0);

    // Control write in the expiry clk keeps the tone running
    wr(3'd3, 8'h01); wr(3'd4, 8'd1);
    run_ticks(999);
    @(negedge clk);
    enable_1mhz = 1'b1;
    bus_address = 16'hA513; bus_io = 1'b1; bus_write = 1'b1; bus_write_data = 8'h01;
    @(negedge clk);
    enable_1mhz = 1'b0; bus_write = 1'b0; bus_io = 1'b0;
    @(negedge clk);
    rd(3'd3, 8'h01, "t5_ctrl");
    rd(3'd4, 8'h00, "t5_dur");
    chk("t5_active", tone_active, 1'b1);
    lvl_mon = 1'b1;
    exp_lvl(16'h8000, 5, "t5_rise");
    exp_lvl(16'h0000, 5, "t5_fall");
    run_ticks(6);

    // Asynchronous reset with tone high and a read-ready pulse in flight
    exp_lvl(16'h8000, 5, "t6_rise");
    run_ticks(5);
    lvl_mon = 1'b0;
    @(negedge clk);
    bus_address = 16'hA512; bus_io = 1'b1; bus_read = 1'b1;
    rd_q.push_back(rd_exp_t'{8'h80, cyc + 1, "t6_vol"});
    @(negedge clk);
    bus_read = 1'b0; bus_io = 1'b0;
    chk("t6_pre_ready", bus_read_ready, 1'b1);
    chk("t6_pre_level", signal_level, 16'h8000);
    #2 n_reset = 1'b0;
    #1;
    chk("t6_async_level", signal_level, 16'h0000);
    chk("t6_async_ready", bus_read_ready, 1'b0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    rd(3'd1, 8'h00, "t6_phi");
    rd(3'd0, 8'h00, "t6_plo");
    rd(3'd2, 8'hFF, "t6_vol_rst");
    chk("t6_active", tone_active, 1'b0);

    repeat (5) @(negedge clk);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("lvl_q_empty", lvl_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
